// File: rtl/decoder9_route_ctrl_if.sv
// ============================================================================
// decoder9_route_ctrl_if : flit, decoder In/S, credit and status signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface decoder9_route_ctrl_if;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] dec_data;
    logic       dec_valid;
    logic       dec_ready;
    logic       s_data;
    logic       s_valid;
    logic       s_ready;
    logic       credit_ret0;
    logic       credit_ret1;
    logic       cur_route;
    logic       busy;
    logic       err;

    modport master (
        output in_data, in_valid, dec_ready, s_ready, credit_ret0, credit_ret1,
        input  in_ready, dec_data, dec_valid, s_data, s_valid, cur_route, busy, err
    );

    modport slave (
        input  in_data, in_valid, dec_ready, s_ready, credit_ret0, credit_ret1,
        output in_ready, dec_data, dec_valid, s_data, s_valid, cur_route, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/decoder9_route_ctrl.sv
// ============================================================================
// decoder9_route_ctrl : packet route locking, select/data issue and
//                       per-output credit tracking for a 1-of-2 decoder leaf
// Rev 1.0
// ============================================================================
`default_nettype none

module decoder9_route_ctrl #(
    parameter int ADDR_BIT = 0,
    parameter int CREDITS  = 4,
    parameter int CW       = $clog2(CREDITS + 1)
) (
    input  wire                   CLK,
    input  wire                   _RESET,
    decoder9_route_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t        state_q,     state_d;
    logic          cur_route_q, cur_route_d;
    logic [8:0]    dec_data_q,  dec_data_d;
    logic          dec_valid_q, dec_valid_d;
    logic          s_data_q,    s_data_d;
    logic          s_valid_q,   s_valid_d;
    logic          err_q,       err_d;
    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];

    logic          route;
    logic          in_ready;
    logic          accept;
    logic [1:0]    ret;

    always_comb begin
        ret      = {bus.credit_ret1, bus.credit_ret0};
        route    = (state_q == ST_HEAD) ? bus.in_data[ADDR_BIT] : cur_route_q;
        // Reset input gates acceptance combinationally so nothing is taken while held.
        in_ready = _RESET
                 & (~dec_valid_q | bus.dec_ready)
                 & (~s_valid_q   | bus.s_ready)
                 & (credit_q[route] != '0);
        accept   = bus.in_valid & in_ready;

        state_d     = state_q;
        cur_route_d = cur_route_q;
        dec_data_d  = dec_data_q;
        dec_valid_d = dec_valid_q & ~bus.dec_ready;
        s_data_d    = s_data_q;
        s_valid_d   = s_valid_q & ~bus.s_ready;
        err_d       = err_q;

        if (accept) begin
            dec_data_d  = bus.in_data;
            dec_valid_d = 1'b1;
            s_data_d    = route;
            s_valid_d   = 1'b1;
            if (state_q == ST_HEAD) begin
                cur_route_d = bus.in_data[ADDR_BIT];
                state_d     = bus.in_data[8] ? ST_HEAD : ST_BODY;
            end else if (bus.in_data[8]) begin
                state_d = ST_HEAD;
            end
        end

        for (int r = 0; r < 2; r++) begin
            credit_d[r] = credit_q[r];
            if (accept && (route == 1'(r)) && !ret[r]) begin
                credit_d[r] = credit_q[r] - CW'(1);
            end else if (ret[r] && !(accept && (route == 1'(r)))) begin
                // A return into a full counter is a protocol error; the count is held.
                if (credit_q[r] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[r] = credit_q[r] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q     <= ST_HEAD;
            cur_route_q <= 1'b0;
            dec_data_q  <= '0;
            dec_valid_q <= 1'b0;
            s_data_q    <= 1'b0;
            s_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            credit_q[0] <= CW'(CREDITS);
            credit_q[1] <= CW'(CREDITS);
        end else begin
            state_q     <= state_d;
            cur_route_q <= cur_route_d;
            dec_data_q  <= dec_data_d;
            dec_valid_q <= dec_valid_d;
            s_data_q    <= s_data_d;
            s_valid_q   <= s_valid_d;
            err_q       <= err_d;
            credit_q[0] <= credit_d[0];
            credit_q[1] <= credit_d[1];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.dec_data  = dec_data_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.s_data    = s_data_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.cur_route = cur_route_q;
    assign bus.busy      = (state_q == ST_BODY);
    assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder9_route_ctrl.sv
// ============================================================================
// tb_decoder9_route_ctrl : directed vector bench for decoder9_route_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decoder9_route_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    decoder9_route_ctrl_if bus ();

    decoder9_route_ctrl #(
        .ADDR_BIT (0),
        .CREDITS  (4)
    ) dut (
        .CLK    (clk),
        ._RESET (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] d;
        logic       v, dr, sr, c0, c1;
        logic       rdy, dv;
        logic [8:0] dd;
        logic       sv, sd, busy, err, cur;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] d, input logic v, dr, sr, c0, c1);
        bus.in_data     = d;
        bus.in_valid    = v;
        bus.dec_ready   = dr;
        bus.s_ready     = sr;
        bus.credit_ret0 = c0;
        bus.credit_ret1 = c1;
    endtask

    task automatic check_outs(input string tag, input logic dv, input logic [8:0] dd,
                              input logic sv, sd, busy, err, cur);
        chk({tag, " dec_valid"}, {8'd0, bus.dec_valid}, {8'd0, dv});
        chk({tag, " dec_data"},  bus.dec_data, dd);
        chk({tag, " s_valid"},   {8'd0, bus.s_valid}, {8'd0, sv});
        chk({tag, " s_data"},    {8'd0, bus.s_data}, {8'd0, sd});
        chk({tag, " busy"},      {8'd0, bus.busy}, {8'd0, busy});
        chk({tag, " err"},       {8'd0, bus.err}, {8'd0, err});
        chk({tag, " cur_route"}, {8'd0, bus.cur_route}, {8'd0, cur});
    endtask

    // Entered one time unit after a rising edge; leaves at the same phase.
    task automatic step(input string tag, input vec_t t);
        drive(t.d, t.v, t.dr, t.sr, t.c0, t.c1);
        #4;
        chk({tag, " in_ready"}, {8'd0, bus.in_ready}, {8'd0, t.rdy});
        @(posedge clk);
        #1;
        check_outs(tag, t.dv, t.dd, t.sv, t.sd, t.busy, t.err, t.cur);
    endtask

    function automatic vec_t mk(input logic [8:0] d, input logic v, dr, sr, c0, c1,
                                input logic rdy, dv, input logic [8:0] dd,
                                input logic sv, sd, busy, err, cur);
        vec_t t;
        t.d = d; t.v = v; t.dr = dr; t.sr = sr; t.c0 = c0; t.c1 = c1;
        t.rdy = rdy; t.dv = dv; t.dd = dd; t.sv = sv; t.sd = sd;
        t.busy = busy; t.err = err; t.cur = cur;
        return t;
    endfunction

    task automatic do_reset(input string tag);
        drive(9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk({tag, " in_ready"}, {8'd0, bus.in_ready}, 9'd0);
        check_outs(tag, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs({tag, " held"}, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        //            d     v  dr sr c0 c1  rdy dv dd    sv sd bsy err cur
        tbl[0]  = mk(9'h001, 1, 1, 1, 0, 0,  1, 1, 9'h001, 1, 1, 1, 0, 1);
        tbl[1]  = mk(9'h055, 1, 1, 1, 0, 0,  1, 1, 9'h055, 1, 1, 1, 0, 1);
        tbl[2]  = mk(9'h1AA, 1, 1, 1, 0, 0,  1, 1, 9'h1AA, 1, 1, 0, 0, 1);
        tbl[3]  = mk(9'h000, 0, 1, 1, 0, 0,  1, 0, 9'h1AA, 0, 1, 0, 0, 1);
        tbl[4]  = mk(9'h101, 1, 1, 1, 0, 0,  1, 1, 9'h101, 1, 1, 0, 0, 1);
        tbl[5]  = mk(9'h101, 1, 1, 1, 0, 0,  0, 0, 9'h101, 0, 1, 0, 0, 1);
        tbl[6]  = mk(9'h100, 1, 1, 1, 0, 0,  1, 1, 9'h100, 1, 0, 0, 0, 0);
        tbl[7]  = mk(9'h101, 1, 1, 1, 0, 1,  0, 0, 9'h100, 0, 0, 0, 0, 0);
        tbl[8]  = mk(9'h101, 1, 1, 1, 0, 0,  1, 1, 9'h101, 1, 1, 0, 0, 1);
        tbl[9]  = mk(9'h000, 0, 1, 1, 1, 0,  1, 0, 9'h101, 0, 1, 0, 0, 1);
        tbl[10] = mk(9'h000, 1, 1, 1, 0, 0,  1, 1, 9'h000, 1, 0, 1, 0, 0);
        tbl[11] = mk(9'h003, 1, 1, 1, 0, 0,  1, 1, 9'h003, 1, 0, 1, 0, 0);
        tbl[12] = mk(9'h005, 1, 1, 1, 0, 0,  1, 1, 9'h005, 1, 0, 1, 0, 0);
        tbl[13] = mk(9'h007, 1, 1, 1, 0, 0,  1, 1, 9'h007, 1, 0, 1, 0, 0);
        tbl[14] = mk(9'h108, 1, 1, 1, 0, 0,  0, 0, 9'h007, 0, 0, 1, 0, 0);
        tbl[15] = mk(9'h108, 1, 1, 1, 1, 0,  0, 0, 9'h007, 0, 0, 1, 0, 0);
        tbl[16] = mk(9'h108, 1, 1, 1, 0, 0,  1, 1, 9'h108, 1, 0, 0, 0, 0);
        tbl[17] = mk(9'h000, 1, 1, 1, 0, 1,  0, 0, 9'h108, 0, 0, 0, 0, 0);
        tbl[18] = mk(9'h101, 1, 1, 1, 0, 0,  1, 1, 9'h101, 1, 1, 0, 0, 1);
        tbl[19] = mk(9'h000, 0, 1, 1, 1, 1,  0, 0, 9'h101, 0, 1, 0, 0, 1);

        @(posedge clk);
        #1;
        do_reset("reset0");
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // S stalled for three cycles while D drains immediately.
        do_reset("reset1");
        @(posedge clk);
        #1;
        step("skew0", mk(9'h100, 1, 1, 1, 0, 0, 1, 1, 9'h100, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("skew%0d", i), mk(9'h101, 1, 1, 0, 0, 0, 0, 0, 9'h100, 1, 0, 0, 0, 0));
        end
        step("skew4", mk(9'h101, 1, 1, 1, 0, 0, 1, 1, 9'h101, 1, 1, 0, 0, 1));
        step("skew5", mk(9'h000, 0, 1, 1, 0, 0, 1, 0, 9'h101, 0, 1, 0, 0, 1));

        // Credit overflow on a full counter, then simultaneous decrement and return.
        do_reset("reset2");
        @(posedge clk);
        #1;
        step("ovf0", mk(9'h000, 0, 1, 1, 0, 1, 1, 0, 9'h000, 0, 0, 0, 1, 0));
        step("ovf1", mk(9'h000, 0, 1, 1, 0, 0, 1, 0, 9'h000, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("ovf_send%0d", i), mk(9'h101, 1, 1, 1, 0, 0, 1, 1, 9'h101, 1, 1, 0, 1, 1));
        end
        step("same_edge", mk(9'h101, 1, 1, 1, 0, 1, 1, 1, 9'h101, 1, 1, 0, 1, 1));
        step("last_cred", mk(9'h101, 1, 1, 1, 0, 0, 1, 1, 9'h101, 1, 1, 0, 1, 1));
        step("no_cred",   mk(9'h101, 1, 1, 1, 0, 0, 0, 0, 9'h101, 0, 1, 0, 1, 1));

        // Reset arriving mid-packet with flits still pending.
        step("mid_head", mk(9'h000, 1, 1, 1, 0, 0, 1, 1, 9'h000, 1, 0, 1, 1, 0));
        drive(9'h001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst in_ready", {8'd0, bus.in_ready}, 9'd0);
        check_outs("mid_rst", 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", mk(9'h001, 1, 1, 1, 0, 0, 1, 1, 9'h001, 1, 1, 1, 0, 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder9_route_ctrl.md
# decoder9_route_ctrl

Clocked route controller that sequences a 9-bit, 1-of-2 decoder leaf: it accepts 9-bit flits, derives the route from the head flit of each packet, and issues one select token plus one data flit per accepted flit. It locks the route for the whole packet. Per-output credit counters stop flits from being sent to a full downstream branch. It sits between the router input port and the decoder leaf's In/S channels.

## Interface
- ADDR_BIT, 0: bit of the head flit that selects the output (0 → Out0, 1 → Out1); legal range 0..7.
- CREDITS, 4: downstream buffer depth per output; reset value of each credit counter; must be ≥1.
- CW, $clog2(CREDITS+1): credit counter width (derived, do not override).

- CLK  in  1  clock, rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- in_data  in  9  flit; bit 8 = tail flag, bits 7:0 payload.
- in_valid  in  1  flit offered.
- in_ready  out  1  flit accepted when in_valid && in_ready at a rising edge.
- dec_data  out  9  flit to decoder In channel.
- dec_valid  out  1  dec_data valid.
- dec_ready  in  1  decoder In accepts.
- s_data  out  1  select token (route) to decoder S channel.
- s_valid  out  1  s_data valid.
- s_ready  in  1  decoder S accepts.
- credit_ret0  in  1  one-cycle pulse: one Out0 slot freed.
- credit_ret1  in  1  one-cycle pulse: one Out1 slot freed.
- cur_route  out  1  locked route of the packet in progress.
- busy  out  1  high in BODY state (packet open).
- err  out  1  sticky; set on credit overflow.

## Operation
- FSM states: HEAD, BODY. Reset → HEAD.
- Route selection: in HEAD, route = in_data[ADDR_BIT]. In BODY, route = cur_route.
- On acceptance in HEAD, cur_route ← in_data[ADDR_BIT]. If in_data[8]=0, go to BODY; otherwise stay in HEAD (single-flit packet).
- On acceptance in BODY, stay in BODY until a flit with in_data[8]=1 is accepted, then go to HEAD.
- Output stage: two independent pending registers, D (dec_data/dec_valid) and S (s_data/s_valid).
- On acceptance, both are loaded: dec_data ← in_data, s_data ← route, and both valids are set.
- Each valid clears on its own handshake (dec_valid && dec_ready, s_valid && s_ready). Data holds stable while valid.
- in_ready is true when all three hold:
  - D is free or completing this cycle;
  - S is free or completing this cycle;
  - credit[route] > 0.
  - in_ready may depend combinationally on in_data in HEAD.
- Credits: credit[r] decrements on acceptance of a flit routed to r and increments on credit_ret_r.
- Both events on the same counter in the same cycle → counter unchanged.
- credit_ret_r while credit[r] == CREDITS (and no decrement in that cycle) → counter held, err set.
- A zero credit on one route blocks only flits to that route; in HEAD, a head flit to the other route is accepted.
- err clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - in_ready=0 while _RESET low;
  - dec_valid=0, s_valid=0, dec_data=0, s_data=0, cur_route=0, busy=0, err=0;
  - credit0=credit1=CREDITS, state HEAD.
- Reset mid-packet discards the pending flits and packet state. The first flit after reset is treated as a head flit.
- Latency: flit accepted at edge N → dec_valid, s_valid high after edge N.
- Throughput: one flit per cycle when dec_ready, s_ready and credits stay available.
- Credit effect: a decrement at edge N is visible in in_ready in cycle N+1. A credit_ret pulse sampled at edge N makes in_ready possible in cycle N+1.
- Skew: S may be accepted many cycles before D (or the reverse). The next flit waits until both pending registers are free.

## Test plan
- Reset with CREDITS=4, ADDR_BIT=0. Send head 0x001 (route 1), body 0x055, tail 0x1AA with the decoder always ready → s_data=1 on all three; dec_data 0x001, 0x055, 0x1AA; busy high after the head and low after the tail; credit1=1.
- Single-flit packets 0x100 then 0x101 → s_data 0 then 1; state stays HEAD; busy never asserts.
- No credit returns, 5 flits to route 0 → first 4 accepted back-to-back, in_ready low on the 5th. One credit_ret0 pulse → 5th accepted on the next cycle.
- Hold s_ready=0 for 3 cycles with dec_ready=1 → dec_valid drops after 1 cycle, s_valid held 3 cycles, next flit stalls until S completes; no flit is lost or duplicated.
- credit_ret1 pulse while credit1=4 → err=1 and stays set, credit1 stays 4. Decrement and credit_ret on the same edge → counter unchanged.
- Assert _RESET mid-packet after the head flit → outputs return to reset values immediately; the next flit 0x001 is routed as a head flit (s_data=1).
